// File: rtl/fifo_nibble_packer_pkg.sv
// rtl/fifo_nibble_packer_pkg.sv - shared state type and width helpers for the nibble packer
package fifo_nibble_packer_pkg;

    typedef enum logic {FILL = 1'b0, SEND = 1'b1} pack_state_t;

    function automatic int out_w(input int width, input int pack);
        return width * pack;
    endfunction

    function automatic int cnt_w(input int pack);
        return $clog2(pack) + 1;
    endfunction

endpackage

// File: rtl/fifo_nibble_packer_if.sv
// rtl/fifo_nibble_packer_if.sv - FIFO pop handshake and packed-word output handshake bundle
interface fifo_nibble_packer_if #(
    parameter int WIDTH = 4,
    parameter int PACK  = 4
);
    import fifo_nibble_packer_pkg::*;

    localparam int OUT_W = out_w(WIDTH, PACK);
    localparam int CNT_W = cnt_w(PACK);

    logic             empty;
    logic             pop_req;
    logic             pop_ack;
    logic [WIDTH-1:0] data_out;
    logic             out_req;
    logic             out_ack;
    logic [OUT_W-1:0] out_data;
    logic [CNT_W-1:0] out_cnt;

    modport master (
        input  empty, pop_ack, data_out, out_ack,
        output pop_req, out_req, out_data, out_cnt
    );

    modport slave (
        output empty, pop_ack, data_out, out_ack,
        input  pop_req, out_req, out_data, out_cnt
    );

endinterface

// File: rtl/fifo_nibble_packer_pack_idle_timer.sv
// rtl/fifo_nibble_packer_pack_idle_timer.sv - idle cycle counter that flushes a partial word
module pack_idle_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic fire
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [TW-1:0] timer;

    assign fire = enable && (timer == TW'(TIMEOUT - 1));

    // Firing always leaves FILL, so holding on fire is all the saturation needed
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            timer <= '0;
        end else if (enable && !fire) begin
            timer <= timer + TW'(1);
        end
    end

endmodule

// File: rtl/fifo_nibble_packer.sv
// rtl/fifo_nibble_packer.sv - drains the nibble FIFO and packs PACK nibbles LSB-first per word
module fifo_nibble_packer
    import fifo_nibble_packer_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int PACK    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_nibble_packer_if.master bus
);
    localparam int OUT_W = out_w(WIDTH, PACK);
    localparam int CNT_W = cnt_w(PACK);

    pack_state_t      state;
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] slots;
    logic [CNT_W-1:0] out_cnt;
    logic             pop_req;
    logic             out_req;

    logic pop_hsk;
    logic out_hsk;
    logic timer_en;
    logic timer_clr;
    logic timer_fire;

    assign pop_hsk   = pop_req && bus.pop_ack;
    assign out_hsk   = out_req && bus.out_ack;
    assign timer_en  = (state == FILL) && (count != '0) && !pop_req;
    assign timer_clr = pop_hsk || out_hsk;

    pack_idle_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .enable(timer_en),
        .clear (timer_clr),
        .fire  (timer_fire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FILL;
            count   <= '0;
            slots   <= '0;
            out_cnt <= '0;
            pop_req <= 1'b0;
            out_req <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (pop_hsk) begin
                        for (int i = 0; i < PACK; i++) begin
                            if (count == CNT_W'(i)) begin
                                slots[i*WIDTH +: WIDTH] <= bus.data_out;
                            end
                        end
                        count   <= count + CNT_W'(1);
                        pop_req <= 1'b0;
                        if (count == CNT_W'(PACK - 1)) begin
                            state   <= SEND;
                            out_req <= 1'b1;
                            out_cnt <= count + CNT_W'(1);
                        end
                    end else if (timer_fire) begin
                        // Timeout wins over a fresh pop request in the same cycle
                        state   <= SEND;
                        out_req <= 1'b1;
                        out_cnt <= count;
                    end else if (!pop_req && !bus.empty) begin
                        pop_req <= 1'b1;
                    end
                end
                SEND: begin
                    if (out_hsk) begin
                        state   <= FILL;
                        out_req <= 1'b0;
                        count   <= '0;
                        slots   <= '0;
                        out_cnt <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.pop_req  = pop_req;
    assign bus.out_req  = out_req;
    assign bus.out_data = slots;
    assign bus.out_cnt  = out_cnt;

endmodule
